mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port 512x16 data/instruction RAM between the CPU and an I/O requester (debug loader / DMA). It sits between both masters and the RAM's command/address/data pins, latches one request at a time, sequences the RAM's one-cycle synchronous read, and returns a registered read word with a one-cycle acknowledge. Round-robin arbitration prevents either master from starving the other.

## Interface
- No parameters. Address width is fixed at 9 and data width at 16.
- Memory command encoding: MWRITE = 2'b00, MREAD = 2'b01, MNONE = 2'b10 (idle); 2'b11 is illegal.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `cpu_req` input 1: CPU request; held until `cpu_ack`.
- `cpu_cmd` input 2, `cpu_addr` input 9, `cpu_wdata` input 16: CPU command, address and write data; held stable while `cpu_req`=1.
- `cpu_ack` output 1: one-cycle completion pulse to the CPU.
- `cpu_rdata` output 16: registered read data for the CPU; holds until the CPU's next read completes.
- `io_req`, `io_cmd`, `io_addr`, `io_wdata`, `io_ack`, `io_rdata`: same widths and meaning, for the I/O master.
- `mem_cmd` output 2, `mem_addr` output 9, `mem_wdata` output 16: RAM port.
- `mem_rdata` input 16: RAM read data, valid in the cycle after MREAD and address are presented.
- `owner` output 1: current or last granted master (0 = CPU, 1 = I/O).
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, RD1, RD2, WR, ACK.
- IDLE: `mem_cmd`=MNONE. If any request is present at the clock edge:
  - Select the winner.
  - Latch its cmd, addr and wdata into internal registers, and set `owner`.
  - Next state is RD1 for MREAD, WR for MWRITE, ACK for an illegal cmd (2'b1x).
- Arbitration:
  - If only one request is present, that master wins.
  - If both are present, the master not equal to `last` wins.
  - `last` updates to the winner at the grant edge. Reset value of `last` is I/O, so the CPU wins the first tie.
- RD1: `mem_cmd`=MREAD, `mem_addr`=latched addr. Next state is RD2.
- RD2: `mem_cmd`=MREAD, `mem_addr` unchanged. `mem_rdata` is captured into the owner's rdata register at the edge leaving RD2. Next state is ACK.
- WR: `mem_cmd`=MWRITE, `mem_addr`=latched addr, `mem_wdata`=latched wdata. Next state is ACK.
- ACK: `mem_cmd`=MNONE. The owner's ack is 1, the other master's ack is 0. Next state is always IDLE; no arbitration happens in ACK.
- Illegal cmd: no RAM access, the ack is still issued, and rdata is unchanged.
- The non-owner's rdata register is never modified by another master's transaction.
- `mem_addr` and `mem_wdata` hold their latched values in IDLE and ACK. They change only at a grant edge.
- Requester rule: drop `req` on the same edge at which ack is sampled high. If `req` is still high in the following IDLE cycle, it is a new request.

## Timing
- Read latency: `req` seen in IDLE at cycle 0 → RD1 in cycle 1 → RD2 in cycle 2 → ack and valid rdata in cycle 3. One read occupies 4 cycles including IDLE.
- Write latency: IDLE at cycle 0 → WR in cycle 1 (RAM written at the end of cycle 1) → ack in cycle 2. One write occupies 3 cycles.
- Back-to-back transactions return through IDLE; there is no ACK→RD1 bypass.
- Worst-case wait for a continuously requesting master is one foreign transaction (4 cycles) plus its own.
- Reset, applied asynchronously at any time including mid-transaction:
  - State goes to IDLE; `mem_cmd`=MNONE.
  - `mem_addr`=0 and `mem_wdata`=0.
  - Both acks are 0 and both rdata registers are 0.
  - `owner`=0, `last`=1, `busy`=0.
  - A write in progress is aborted.
- A request arriving during RD1, RD2, WR or ACK is not sampled until the next IDLE edge.

## Test plan
- Reset mid-read: assert `reset` low during RD2 → outputs return immediately to their reset values (`mem_cmd`=2'b10, `cpu_rdata`=0, `busy`=0); after release, the FSM is in IDLE.
- CPU read only: RAM[0x005]=16'hBEEF; CPU reads 0x005 → `mem_cmd`=MREAD in cycles 1–2, `cpu_ack`=1 in cycle 3 only, `cpu_rdata`=16'hBEEF; `io_rdata` is unchanged.
- I/O write then CPU read: I/O writes 16'h1234 to 0x1FF → `io_ack` in cycle 2. CPU then reads 0x1FF → `cpu_rdata`=16'h1234.
- Simultaneous requests after reset: both read different addresses → CPU is granted first (`owner`=0). I/O is granted at the next IDLE with `owner`=1, and `io_ack` arrives 4 cycles after `cpu_ack`.
- Continuous contention: both hold `req` for 4 transactions each, re-raising `req` after ack → grants strictly alternate CPU, I/O, CPU, I/O…; no master is served twice in a row.
- Illegal cmd: CPU issues `cpu_cmd`=2'b11 → `cpu_ack` in cycle 1, `mem_cmd` stays MNONE throughout, RAM and `cpu_rdata` are unchanged.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one requester channel (request/command/address/write data, ack/read data)
// master: the requesting side (CPU or I/O); slave: the arbiter side.
`timescale 1ns/1ps
interface mem_arbiter_if;
    logic        req;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;
    modport master (output req, cmd, addr, wdata, input ack, rdata);
    modport slave  (input req, cmd, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port 512x16 RAM between a CPU and an I/O master.
// Ports: clk, reset (async, active low); cpu/io requester channels (mem_arbiter_if.slave);
// mem_cmd/mem_addr/mem_wdata/mem_rdata RAM port; owner = current/last granted master (0 CPU, 1 I/O);
// busy = FSM not idle.
`timescale 1ns/1ps
module mem_arbiter (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave cpu,
    mem_arbiter_if.slave io,
    output logic [1:0]   mem_cmd,
    output logic [8:0]   mem_addr,
    output logic [15:0]  mem_wdata,
    input  logic [15:0]  mem_rdata,
    output logic         owner,
    output logic         busy
);
    localparam logic [1:0] MWRITE = 2'b00, MREAD = 2'b01, MNONE = 2'b10;
    typedef enum logic [2:0] {IDLE, RD1, RD2, WR, ACK} state_t;
    state_t      state, state_nx;
    logic        last, any_req, grant_io;
    logic [1:0]  win_cmd;
    logic [15:0] cpu_rdata, io_rdata;
    assign any_req  = cpu.req | io.req;
    // on a tie the master that was not served last wins
    assign grant_io = io.req & (~cpu.req | ~last);
    assign win_cmd  = grant_io ? io.cmd : cpu.cmd;
    always_comb begin
        state_nx = IDLE;
        mem_cmd  = MNONE;
        case (state)
            IDLE: state_nx = !any_req ? IDLE : win_cmd == MREAD ? RD1 : win_cmd == MWRITE ? WR : ACK;
            RD1: begin
                mem_cmd  = MREAD;
                state_nx = RD2;
            end
            RD2: begin
                mem_cmd  = MREAD;
                state_nx = ACK;
            end
            WR: begin
                mem_cmd  = MWRITE;
                state_nx = ACK;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            owner     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            io_rdata  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                owner     <= grant_io;
                last      <= grant_io;
                mem_addr  <= grant_io ? io.addr : cpu.addr;
                mem_wdata <= grant_io ? io.wdata : cpu.wdata;
            end
            if (state == RD2 && !owner)
                cpu_rdata <= mem_rdata;
            if (state == RD2 && owner)
                io_rdata <= mem_rdata;
        end
    end
    assign cpu.ack   = state == ACK && !owner;
    assign io.ack    = state == ACK && owner;
    assign cpu.rdata = cpu_rdata;
    assign io.rdata  = io_rdata;
    assign busy      = state != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random transactions checked against a transaction-level model
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam logic [1:0] MWRITE = 2'b00, MREAD = 2'b01, MNONE = 2'b10;
    typedef struct packed {logic [1:0] cmd; logic [8:0] addr; logic [15:0] wdata;} txn_t;
    logic        clk, reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        owner, busy;
    mem_arbiter_if cpu_bus ();
    mem_arbiter_if io_bus ();
    mem_arbiter dut (
        .clk(clk), .reset(reset), .cpu(cpu_bus), .io(io_bus),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
    );
    logic [15:0] ram [512];
    always @(posedge clk) begin
        if (mem_cmd == MWRITE) ram[mem_addr] <= mem_wdata;
        if (mem_cmd == MREAD) mem_rdata <= ram[mem_addr];
    end
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int          total = 0, bad = 0;
    txn_t        tx [2][8];
    int          n [2];
    int          exp_cyc [2][8];
    logic [15:0] exp_own [2][8], exp_oth [2][8];
    logic [15:0] shadow [512];
    logic [15:0] m_rd [2];
    int          m_last;
    logic [8:0]  pool [8];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask
    task automatic add(input int m, input logic [1:0] c, input logic [8:0] a, input logic [15:0] w);
        tx[m][n[m]] = '{c, a, w};
        n[m]++;
    endtask
    task automatic set_bus(input int m, input logic r, input txn_t t);
        if (m == 0) begin
            cpu_bus.req = r; cpu_bus.cmd = t.cmd; cpu_bus.addr = t.addr; cpu_bus.wdata = t.wdata;
        end else begin
            io_bus.req = r; io_bus.cmd = t.cmd; io_bus.addr = t.addr; io_bus.wdata = t.wdata;
        end
    endtask
    task automatic model_reset();
        m_rd[0] = '0;
        m_rd[1] = '0;
        m_last = 1;
    endtask
    // Call at a negedge while the DUT is idle; issues all queued transactions of both masters.
    task automatic run();
        int p [2];
        int d [2];
        int t, w, lat, k, budget, rds, wrs, rd_cnt, wr_cnt;
        logic [1:0] acked;
        txn_t cur;
        p = '{0, 0}; t = 0; rds = 0; wrs = 0;
        while (p[0] < n[0] || p[1] < n[1]) begin
            w = (p[0] < n[0] && p[1] < n[1]) ? 1 - m_last : (p[0] < n[0]) ? 0 : 1;
            m_last = w;
            cur = tx[w][p[w]];
            lat = cur.cmd == MREAD ? 4 : cur.cmd == MWRITE ? 3 : 2;
            if (cur.cmd == MREAD) begin m_rd[w] = shadow[cur.addr]; rds++; end
            if (cur.cmd == MWRITE) begin shadow[cur.addr] = cur.wdata; wrs++; end
            exp_cyc[w][p[w]] = t + lat - 1;
            exp_own[w][p[w]] = m_rd[w];
            exp_oth[w][p[w]] = m_rd[1 - w];
            t += lat;
            p[w]++;
        end
        budget = t + 8;
        d = '{0, 0}; k = 0; rd_cnt = 0; wr_cnt = 0;
        for (int m = 0; m < 2; m++) set_bus(m, n[m] > 0, n[m] > 0 ? tx[m][0] : '0);
        while ((d[0] < n[0] || d[1] < n[1]) && k < budget) begin
            @(negedge clk);
            k++;
            if (mem_cmd == MREAD) rd_cnt++;
            if (mem_cmd == MWRITE) wr_cnt++;
            acked = {io_bus.ack, cpu_bus.ack};
            for (int m = 0; m < 2; m++) begin
                if (acked[m]) begin
                    if (d[m] >= n[m]) chk($sformatf("spurious_ack_m%0d", m), acked[m], 0);
                    else begin
                        chk($sformatf("ack_cycle_m%0d_t%0d", m, d[m]), k, exp_cyc[m][d[m]]);
                        chk($sformatf("rdata_own_m%0d", m), m == 0 ? cpu_bus.rdata : io_bus.rdata, exp_own[m][d[m]]);
                        chk($sformatf("rdata_other_m%0d", m), m == 0 ? io_bus.rdata : cpu_bus.rdata, exp_oth[m][d[m]]);
                        chk($sformatf("owner_at_ack_m%0d", m), owner, m);
                        d[m]++;
                    end
                end
            end
            for (int m = 0; m < 2; m++) begin
                cur = d[m] < n[m] ? tx[m][d[m]] : '0;
                set_bus(m, !acked[m] && d[m] < n[m], cur);
            end
        end
        chk("all_acks_seen", d[0] + d[1], n[0] + n[1]);
        chk("read_cycles", rd_cnt, 2 * rds);
        chk("write_cycles", wr_cnt, wrs);
        n = '{0, 0};
        @(negedge clk);
    endtask
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_cmd"}, mem_cmd, MNONE);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_acks"}, {cpu_bus.ack, io_bus.ack}, 0);
        chk({tag, "_cpu_rdata"}, cpu_bus.rdata, 0);
        chk({tag, "_io_rdata"}, io_bus.rdata, 0);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask
    initial begin
        pool = '{9'h000, 9'h001, 9'h0AA, 9'h100, 9'h155, 9'h0FF, 9'h1FE, 9'h080};
        n = '{0, 0};
        set_bus(0, 1'b0, '0);
        set_bus(1, 1'b0, '0);
        reset = 1'b0;
        model_reset();
        #1;
        chk_reset_vals("por");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        // continuous contention: four writes each, strict alternation starting with the CPU
        for (int i = 0; i < 4; i++) begin
            add(0, MWRITE, pool[i], 16'(16'hA000 + i));
            add(1, MWRITE, pool[i + 4], 16'(16'hB000 + i));
        end
        run();
        add(1, MWRITE, 9'h005, 16'hBEEF);
        run();
        add(0, MREAD, 9'h005, '0);
        run();
        add(1, MWRITE, 9'h1FF, 16'h1234);
        run();
        add(0, MREAD, 9'h1FF, '0);
        run();
        // reset while in RD2
        set_bus(0, 1'b1, '{MREAD, 9'h005, 16'h0});
        repeat (2) @(negedge clk);
        chk("mid_read_busy", busy, 1);
        chk("mid_read_cmd", mem_cmd, MREAD);
        #1 reset = 1'b0;
        #1;
        chk_reset_vals("mid_read");
        set_bus(0, 1'b0, '0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("after_reset_busy", busy, 0);
        // simultaneous reads right after reset: CPU first, I/O ack four cycles later
        add(0, MREAD, 9'h005, '0);
        add(1, MREAD, 9'h1FF, '0);
        run();
        // illegal command: ack in cycle 1, no RAM traffic, rdata unchanged
        add(0, 2'b11, pool[0], 16'hDEAD);
        run();
        add(0, MREAD, pool[0], '0);
        run();
        // reset during WR: the write must not reach the RAM
        set_bus(0, 1'b1, '{MWRITE, pool[2], ~shadow[pool[2]]});
        @(negedge clk);
        chk("mid_write_cmd", mem_cmd, MWRITE);
        #1 reset = 1'b0;
        #1;
        chk_reset_vals("mid_write");
        set_bus(0, 1'b0, '0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("aborted_write_ram", ram[pool[2]], shadow[pool[2]]);
        // random mixes of reads, writes and illegal commands from both masters
        for (int r = 0; r < 25; r++) begin
            for (int m = 0; m < 2; m++) begin
                int cnt;
                cnt = $urandom_range(0, 3);
                if (m == 1 && n[0] == 0 && cnt == 0) cnt = 1;
                for (int j = 0; j < cnt; j++) begin
                    int sel;
                    logic [1:0] c;
                    sel = $urandom_range(0, 9);
                    c = sel < 4 ? MREAD : sel < 8 ? MWRITE : sel == 8 ? 2'b10 : 2'b11;
                    add(m, c, pool[$urandom_range(0, 7)], 16'($urandom));
                end
            end
            run();
        end
        for (int i = 0; i < 8; i++) begin
            add(i % 2, MREAD, pool[i], '0);
            run();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
